// File: rtl/cmd_arbiter.sv
// Shares the cmd_proc command port between the UART wrapper (via a small FIFO) and the
// tour sequencer; round-robin with a tour lock, response byte generation and a watchdog.
module cmd_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int TMO_W      = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] uart_cmd,
    input  logic        uart_cmd_rdy,
    output logic        uart_clr,
    input  logic        tour_req,
    input  logic [15:0] tour_cmd,
    input  logic        tour_last,
    output logic        tour_ack,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        resp_vld,
    output logic        tour_active,
    output logic        tmo_err
);

    localparam int              PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]  FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    // Last counter value before expiry: BUSY lasts 2^TMO_W-1 cycles when cmd_proc is silent.
    localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W - 1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } state_t;

    state_t             r_state;
    logic [15:0]        r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_grant_tour;
    logic               r_is_last;
    logic [TMO_W-1:0]   r_wdog;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_uart_elig;
    logic w_tour_elig;
    logic w_grant_uart;
    logic w_grant_tour;

    assign w_full  = (r_count == FIFO_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = (r_state == ISSUE) && clr_cmd_rdy && !r_grant_tour;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push  = uart_cmd_rdy && !uart_clr && (!w_full || w_pop);

    // r_grant_tour doubles as the round-robin pointer: it names the last source granted.
    assign w_uart_elig  = !w_empty && !tour_active;
    assign w_tour_elig  = tour_req;
    assign w_grant_tour = w_tour_elig && (!w_uart_elig || !r_grant_tour);
    assign w_grant_uart = w_uart_elig && (!w_tour_elig || r_grant_tour);

    assign tour_ack = (r_state == ISSUE) && clr_cmd_rdy && r_grant_tour;

    // NOTE: storage is not reset; r_count and the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= uart_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            uart_clr <= 1'b0;
        end else begin
            uart_clr <= w_push;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant_tour <= 1'b0;
            r_is_last    <= 1'b0;
            r_wdog       <= '0;
            cmd          <= '0;
            cmd_rdy      <= 1'b0;
            resp         <= '0;
            resp_vld     <= 1'b0;
            tour_active  <= 1'b0;
            tmo_err      <= 1'b0;
        end else begin
            resp_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_tour || w_grant_uart) begin
                        r_state      <= ISSUE;
                        cmd_rdy      <= 1'b1;
                        r_grant_tour <= w_grant_tour;
                        r_is_last    <= w_grant_tour && tour_last;
                        cmd          <= w_grant_tour ? tour_cmd : r_fifo_mem[r_rd_ptr];
                        if (w_grant_tour) begin
                            tour_active <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (clr_cmd_rdy) begin
                        r_state <= BUSY;
                        cmd_rdy <= 1'b0;
                    end
                end
                BUSY: begin
                    if (send_resp) begin
                        r_state  <= IDLE;
                        r_wdog   <= '0;
                        resp_vld <= 1'b1;
                        resp     <= (!r_grant_tour || r_is_last) ? 8'hA5 : 8'h5A;
                        if (r_grant_tour && r_is_last) begin
                            tour_active <= 1'b0;
                        end
                    end else if (r_wdog == WDOG_LAST) begin
                        r_state     <= IDLE;
                        r_wdog      <= '0;
                        tmo_err     <= 1'b1;
                        tour_active <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: UART path, tour pairs and lock, round-robin,
// FIFO backpressure, watchdog expiry (TMO_W=4) and mid-operation reset.
module tb_cmd_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] uart_cmd;
    logic        uart_cmd_rdy;
    logic        uart_clr;
    logic        tour_req;
    logic [15:0] tour_cmd;
    logic        tour_last;
    logic        tour_ack;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_vld;
    logic        tour_active;
    logic        tmo_err;

    int n_checks;
    int n_pass;
    int n_uart_clr;

    cmd_arbiter #(.FIFO_DEPTH(2), .TMO_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_cmd     (uart_cmd),
        .uart_cmd_rdy (uart_cmd_rdy),
        .uart_clr     (uart_clr),
        .tour_req     (tour_req),
        .tour_cmd     (tour_cmd),
        .tour_last    (tour_last),
        .tour_ack     (tour_ack),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp),
        .resp_vld     (resp_vld),
        .tour_active  (tour_active),
        .tmo_err      (tmo_err)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!cmd_rdy && n < 30) begin
            step();
            n++;
        end
        check({tag, "_rdy"}, 32'(cmd_rdy), 32'd1);
    endtask

    // Presents a UART command and waits (bounded) until the wrapper model sees uart_clr.
    task automatic uart_send(input string tag, input logic [15:0] c);
        int n = 0;
        uart_cmd     = c;
        uart_cmd_rdy = 1'b1;
        do begin
            step();
            n++;
        end while (uart_cmd_rdy && n < 30);
        check({tag, "_captured"}, 32'(uart_cmd_rdy), 32'd0);
    endtask

    // Plays cmd_proc for one command; for tour commands, applies the sequencer's next request after ack.
    task automatic serve(input string tag, input logic [15:0] exp_cmd, input logic [7:0] exp_resp,
                         input logic is_tour, input logic act_after,
                         input logic nreq, input logic [15:0] ncmd, input logic nlast);
        wait_rdy(tag);
        check({tag, "_cmd"}, 32'(cmd), 32'(exp_cmd));
        check({tag, "_active"}, 32'(tour_active), 32'(is_tour));
        clr_cmd_rdy = 1'b1;
        #1;
        check({tag, "_ack"}, 32'(tour_ack), 32'(is_tour));
        step();
        clr_cmd_rdy = 1'b0;
        check({tag, "_rdy_drop"}, {30'd0, cmd_rdy, tour_ack}, 32'd0);
        if (is_tour) begin
            tour_req  = nreq;
            tour_cmd  = ncmd;
            tour_last = nlast;
        end
        step();
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        check({tag, "_resp"}, {23'd0, resp_vld, resp}, {23'd0, 1'b1, exp_resp});
        check({tag, "_after"}, {15'd0, tour_active, cmd}, {15'd0, act_after, exp_cmd});
        step();
        check({tag, "_vld_pulse"}, 32'(resp_vld), 32'd0);
    endtask

    initial begin
        int base;
        logic saw;
        n_checks     = 0;
        n_pass       = 0;
        n_uart_clr   = 0;
        rst_n        = 1'b0;
        uart_cmd     = '0;
        uart_cmd_rdy = 1'b0;
        tour_req     = 1'b0;
        tour_cmd     = '0;
        tour_last    = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;

        // UART wrapper model: drops its request when it sees the capture pulse.
        fork
            forever begin
                @(negedge clk);
                if (uart_clr) begin
                    uart_cmd_rdy = 1'b0;
                    n_uart_clr++;
                end
            end
        join_none

        step();
        check("reset_outs", {2'd0, cmd, cmd_rdy, resp, resp_vld, tour_active, tmo_err, uart_clr, tour_ack}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Single UART command: capture pulse one cycle later, cmd_rdy one cycle after that.
        uart_cmd     = 16'h2005;
        uart_cmd_rdy = 1'b1;
        step();
        check("s1_uart_clr", {30'd0, uart_clr, cmd_rdy}, 32'b10);
        step();
        check("s1_issue", {15'd0, uart_clr, cmd_rdy, cmd}, {15'd0, 1'b0, 1'b1, 16'h2005});
        serve("s1", 16'h2005, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        // Tour pair: intermediate move then final move.
        tour_cmd  = 16'h2002;
        tour_last = 1'b0;
        tour_req  = 1'b1;
        serve("s2a", 16'h2002, 8'h5A, 1'b1, 1'b1, 1'b1, 16'h33F1, 1'b1);
        serve("s2b", 16'h33F1, 8'hA5, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);

        // Contention right after a tour grant: UART wins, tour follows.
        uart_cmd     = 16'h3003;
        uart_cmd_rdy = 1'b1;
        step();
        tour_cmd  = 16'h4004;
        tour_last = 1'b1;
        tour_req  = 1'b1;
        serve("s4u", 16'h3003, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        serve("s4t", 16'h4004, 8'hA5, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);

        // Tour lock held while UART commands queue up; third one backpressured.
        tour_cmd  = 16'h1111;
        tour_last = 1'b0;
        tour_req  = 1'b1;
        wait_rdy("s3_tour");
        base = n_uart_clr;
        uart_send("s3_a", 16'hA001);
        uart_send("s3_b", 16'hA002);
        uart_cmd     = 16'hA003;
        uart_cmd_rdy = 1'b1;
        repeat (4) step();
        check("s3_backpressure", {15'd0, uart_cmd_rdy, 16'(n_uart_clr - base)}, {15'd0, 1'b1, 16'd2});
        check("s3_hold_issue", {15'd0, cmd_rdy, cmd}, {15'd0, 1'b1, 16'h1111});
        serve("s3t1", 16'h1111, 8'h5A, 1'b1, 1'b1, 1'b1, 16'h2222, 1'b1);
        serve("s3t2", 16'h2222, 8'hA5, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        serve("s3u1", 16'hA001, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        serve("s3u2", 16'hA002, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        serve("s3u3", 16'hA003, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        check("s3_clr_total", 32'(n_uart_clr - base), 32'd3);

        // Watchdog: 15 silent BUSY cycles, then the pending UART command is granted.
        uart_send("s5_a", 16'h5005);
        wait_rdy("s5_first");
        check("s5_cmd", 32'(cmd), 32'h5005);
        uart_send("s5_b", 16'h7007);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        check("s5_busy", 32'(cmd_rdy), 32'd0);
        saw = 1'b0;
        repeat (14) begin
            step();
            saw = saw | resp_vld;
        end
        check("s5_tmo_early", 32'(tmo_err), 32'd0);
        step();
        saw = saw | resp_vld;
        check("s5_tmo", {30'd0, tmo_err, saw}, 32'b10);
        serve("s5_next", 16'h7007, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        check("s5_sticky", 32'(tmo_err), 32'd1);

        // Reset during BUSY with one entry still queued; the entry must be discarded.
        uart_send("s6_a", 16'h8008);
        wait_rdy("s6_first");
        uart_send("s6_b", 16'h9009);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        check("s6_busy", 32'(cmd_rdy), 32'd0);
        rst_n = 1'b0;
        #1;
        check("s6_rst_outs", {2'd0, cmd, cmd_rdy, resp, resp_vld, tour_active, tmo_err, uart_clr, tour_ack}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            step();
            saw = saw | cmd_rdy;
        end
        check("s6_quiet", 32'(saw), 32'd0);
        uart_send("s6_c", 16'hB00B);
        serve("s6_new", 16'hB00B, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
